// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter
//   Drains up to NUM_VC virtual-channel source FIFOs into two destination
//   FIFOs. VC0 has the highest priority; a VC that has been passed over
//   STARVE_LIMIT times is served next. Each popped word goes to the
//   destination selected by its DEST_BIT, two cycles after the pop.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high
//   src_empty        empty flag of each source FIFO
//   src_data         pop data of each source FIFO, VCi on [8i+7:8i]
//   src_read         one-hot pop strobe to the source FIFOs (combinational)
//   dst_almost_full  almost-full of the two destination FIFOs
//   dst_error        error flag of the two destination FIFOs
//   dst_write        one-hot push strobe to the destination FIFOs
//   dst_data         word pushed to the destinations
//   arb_state        FSM state: 00 IDLE, 01 RUN, 10 PAUSE
//   arb_error        sticky error flag
//   idle             IDLE with no word in flight
module vc_pop_arbiter #(
    parameter int DATA_SIZE    = 8,
    parameter int NUM_VC       = 4,
    parameter int DEST_BIT     = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_VC-1:0]           src_empty,
    input  logic [NUM_VC*DATA_SIZE-1:0] src_data,
    output logic [NUM_VC-1:0]           src_read,
    input  logic [1:0]                  dst_almost_full,
    input  logic [1:0]                  dst_error,
    output logic [1:0]                  dst_write,
    output logic [DATA_SIZE-1:0]        dst_data,
    output logic [1:0]                  arb_state,
    output logic                        arb_error,
    output logic                        idle
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      wait_cnt [NUM_VC];
    logic [NUM_VC-1:0]     starved;
    logic [NUM_VC-1:0]     grant;
    logic [VC_W-1:0]       grant_vc;
    logic                  pause;
    logic                  all_empty;
    logic                  pop_any;
    logic                  pop_err;
    logic                  pop_valid_q;
    logic [VC_W-1:0]       pop_vc_q;
    logic [DATA_SIZE-1:0]  pop_word;

    assign pause     = |dst_almost_full;
    assign all_empty = &src_empty;

    // Grant selection. Loops run from the highest index down so the last
    // assignment, i.e. the lowest index, wins. The starved pass runs second
    // so a starved VC overrides plain priority.
    // NOTE: every always_comb output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        grant    = '0;
        grant_vc = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            starved[i] = ~src_empty[i] && (wait_cnt[i] >= LIMIT);
        end
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (~src_empty[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                grant_vc = VC_W'(i);
            end
        end
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (starved[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                grant_vc = VC_W'(i);
            end
        end
    end

    // Pops happen only in RUN with room downstream; grant is empty when
    // every source is empty, so no pop is issued that cycle.
    assign src_read = (state == RUN && !pause) ? grant : '0;
    assign pop_any  = |src_read;
    assign pop_err  = |(src_read & src_empty);

    // The source FIFO presents the popped word one cycle after the strobe.
    always_comb begin
        pop_word = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (pop_vc_q == VC_W'(i)) begin
                pop_word = src_data[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pop_valid_q <= 1'b0;
            pop_vc_q    <= '0;
            dst_write   <= '0;
            dst_data    <= '0;
            arb_error   <= 1'b0;
            // NOTE: the wait counters steer the grant, so this small array
            // is reset along with the control flops, unlike a data memory.
            for (int i = 0; i < NUM_VC; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE:    if (!all_empty && !pause) state <= RUN;
                RUN:     if (pause)                state <= PAUSE;
                         else if (all_empty)       state <= IDLE;
                PAUSE:   if (!pause)               state <= all_empty ? IDLE : RUN;
                default:                           state <= IDLE;
            endcase

            // Stage 1: remember which VC was popped.
            pop_valid_q <= pop_any;
            if (pop_any) begin
                pop_vc_q <= grant_vc;
            end

            // Stage 2: push the word the FIFO now drives; dst_data holds
            // its last value between pushes.
            dst_write <= '0;
            if (pop_valid_q) begin
                dst_write <= pop_word[DEST_BIT] ? 2'b10 : 2'b01;
                dst_data  <= pop_word;
            end

            // A waiting VC counts pops granted to others, saturating at
            // the limit; it restarts when served or when it drains.
            for (int i = 0; i < NUM_VC; i++) begin
                if (src_empty[i] || src_read[i]) begin
                    wait_cnt[i] <= '0;
                end else if (pop_any && wait_cnt[i] != LIMIT) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end

            if (|dst_error || pop_err) begin
                arb_error <= 1'b1;
            end
        end
    end

    assign arb_state = state;
    assign idle      = (state == IDLE) && !pop_valid_q && (dst_write == 2'b00);

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// tb_vc_pop_arbiter
//   Directed bench for vc_pop_arbiter. dut_a uses the default starvation
//   limit, dut_b uses STARVE_LIMIT=2. Each DUT is fed by a small model of
//   four source FIFOs whose empty flag and pop data update on the clock.
module tb_vc_pop_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  dst_almost_full;
    logic [1:0]  dst_error;

    logic [3:0]  src_empty_a, src_empty_b;
    logic [31:0] src_data_a, src_data_b;
    logic [3:0]  src_read_a, src_read_b;
    logic [1:0]  dst_write_a, dst_write_b;
    logic [7:0]  dst_data_a, dst_data_b;
    logic [1:0]  arb_state_a, arb_state_b;
    logic        arb_error_a, arb_error_b;
    logic        idle_a, idle_b;

    vc_pop_arbiter dut_a (
        .clk             (clk),
        .reset           (reset),
        .src_empty       (src_empty_a),
        .src_data        (src_data_a),
        .src_read        (src_read_a),
        .dst_almost_full (dst_almost_full),
        .dst_error       (dst_error),
        .dst_write       (dst_write_a),
        .dst_data        (dst_data_a),
        .arb_state       (arb_state_a),
        .arb_error       (arb_error_a),
        .idle            (idle_a)
    );

    vc_pop_arbiter #(.STARVE_LIMIT(2)) dut_b (
        .clk             (clk),
        .reset           (reset),
        .src_empty       (src_empty_b),
        .src_data        (src_data_b),
        .src_read        (src_read_b),
        .dst_almost_full (dst_almost_full),
        .dst_error       (dst_error),
        .dst_write       (dst_write_b),
        .dst_data        (dst_data_b),
        .arb_state       (arb_state_b),
        .arb_error       (arb_error_b),
        .idle            (idle_b)
    );

    // Source FIFO model, indexed [dut][vc]; 8-entry circular buffers.
    logic [7:0] fmem [2][4][8];
    int         fwr  [2][4];
    int         frd  [2][4];
    int         fcnt [2][4];
    logic [7:0] fout [2][4];

    always_comb begin
        src_empty_a = '0;
        src_empty_b = '0;
        src_data_a  = '0;
        src_data_b  = '0;
        for (int v = 0; v < 4; v++) begin
            src_empty_a[v]        = (fcnt[0][v] == 0);
            src_empty_b[v]        = (fcnt[1][v] == 0);
            src_data_a[v*8 +: 8]  = fout[0][v];
            src_data_b[v*8 +: 8]  = fout[1][v];
        end
    end

    logic [3:0] pop_log_a  [$];
    logic [3:0] pop_log_b  [$];
    logic [9:0] push_log_a [$];

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [3:0] exp_pop_a [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b1000};
    logic [3:0] exp_pop_b [4] = '{4'b0001, 4'b0001, 4'b1000, 4'b0001};
    logic [9:0] exp_push_a[4] = '{10'h101, 10'h102, 10'h103, 10'h213};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int d, input int v, input logic [7:0] w);
        fmem[d][v][fwr[d][v]] = w;
        fwr[d][v]  = (fwr[d][v] + 1) % 8;
        fcnt[d][v] = fcnt[d][v] + 1;
    endtask

    // One clock: capture the pop strobes before the edge, then update the
    // FIFO models and the push log just after it. Returns 2 time units
    // after the edge, where outputs are settled for checking.
    task automatic cycle();
        logic [3:0] ra, rb;
        #1;
        ra = src_read_a;
        rb = src_read_b;
        if (ra != 4'b0000) pop_log_a.push_back(ra);
        if (rb != 4'b0000) pop_log_b.push_back(rb);
        @(posedge clk);
        #1;
        for (int v = 0; v < 4; v++) begin
            if (ra[v] && fcnt[0][v] > 0) begin
                fout[0][v] = fmem[0][v][frd[0][v]];
                frd[0][v]  = (frd[0][v] + 1) % 8;
                fcnt[0][v] = fcnt[0][v] - 1;
            end
            if (rb[v] && fcnt[1][v] > 0) begin
                fout[1][v] = fmem[1][v][frd[1][v]];
                frd[1][v]  = (frd[1][v] + 1) % 8;
                fcnt[1][v] = fcnt[1][v] - 1;
            end
        end
        if (dst_write_a != 2'b00) push_log_a.push_back({dst_write_a, dst_data_a});
        #1;
    endtask

    task automatic clear_logs();
        pop_log_a.delete();
        pop_log_b.delete();
        push_log_a.delete();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int v = 0; v < 4; v++) begin
                fwr[d][v]  = 0;
                frd[d][v]  = 0;
                fcnt[d][v] = 0;
                fout[d][v] = 8'h00;
            end
        end
        reset           = 1'b1;
        dst_almost_full = 2'b00;
        dst_error       = 2'b00;

        // 1: reset held two cycles
        cycle();
        cycle();
        check("rst_src_read",  src_read_a,  4'b0000);
        check("rst_dst_write", dst_write_a, 2'b00);
        check("rst_dst_data",  dst_data_a,  8'h00);
        check("rst_state",     arb_state_a, 2'b00);
        check("rst_error",     arb_error_a, 1'b0);
        check("rst_idle",      idle_a,      1'b1);
        check("rst_state_b",   arb_state_b, 2'b00);
        reset = 1'b0;
        cycle();
        check("rst_idle_after", idle_a, 1'b1);

        // 2: single word 8'h15 on VC2 -> dst1
        clear_logs();
        load(0, 2, 8'h15);
        check("t2_wait_idle", arb_state_a, 2'b00);
        cycle();
        check("t2_run",       arb_state_a, 2'b01);
        check("t2_pop",       src_read_a,  4'b0100);
        cycle();
        check("t2_no_repop",  src_read_a,  4'b0000);
        check("t2_no_push",   dst_write_a, 2'b00);
        check("t2_busy",      idle_a,      1'b0);
        cycle();
        check("t2_push",      dst_write_a, 2'b10);
        check("t2_data",      dst_data_a,  8'h15);
        check("t2_to_idle",   arb_state_a, 2'b00);
        check("t2_idle_busy", idle_a,      1'b0);
        cycle();
        check("t2_push_end",  dst_write_a, 2'b00);
        check("t2_data_hold", dst_data_a,  8'h15);
        check("t2_idle",      idle_a,      1'b1);
        check("t2_pop_count", pop_log_a.size(), 1);

        // 3: VC0 x3 and VC3 x1; strict priority on A, starvation on B
        clear_logs();
        for (int d = 0; d < 2; d++) begin
            load(d, 0, 8'h01);
            load(d, 0, 8'h02);
            load(d, 0, 8'h03);
            load(d, 3, 8'h13);
        end
        repeat (8) cycle();
        check("t3_pop_cnt_a", pop_log_a.size(), 4);
        check("t3_pop_cnt_b", pop_log_b.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_pop_a%0d", i),
                  (i < pop_log_a.size()) ? pop_log_a[i] : 4'hx, exp_pop_a[i]);
            check($sformatf("t3_pop_b%0d", i),
                  (i < pop_log_b.size()) ? pop_log_b[i] : 4'hx, exp_pop_b[i]);
            check($sformatf("t3_push_a%0d", i),
                  (i < push_log_a.size()) ? push_log_a[i] : 10'hx, exp_push_a[i]);
        end
        check("t3_idle_a",  idle_a,      1'b1);
        check("t3_idle_b",  idle_b,      1'b1);
        check("t3_err_b",   arb_error_b, 1'b0);

        // 4: dst0 almost_full during a VC1 burst
        clear_logs();
        for (int i = 0; i < 5; i++) load(0, 1, 8'h0a + 8'(i));
        cycle();
        check("t4_run",        arb_state_a, 2'b01);
        check("t4_pop1",       src_read_a,  4'b0010);
        cycle();
        check("t4_pop2",       src_read_a,  4'b0010);
        cycle();
        dst_almost_full = 2'b01;
        #1;
        check("t4_pop_stop",   src_read_a,  4'b0000);
        check("t4_flight1",    dst_write_a, 2'b01);
        check("t4_flight1_d",  dst_data_a,  8'h0a);
        cycle();
        check("t4_pause",      arb_state_a, 2'b10);
        check("t4_flight2",    dst_write_a, 2'b01);
        check("t4_flight2_d",  dst_data_a,  8'h0b);
        check("t4_pause_pop",  src_read_a,  4'b0000);
        cycle();
        check("t4_drained",    dst_write_a, 2'b00);
        check("t4_still_pause", arb_state_a, 2'b10);
        dst_almost_full = 2'b00;
        #1;
        check("t4_release_pop", src_read_a, 4'b0000);
        cycle();
        check("t4_resume",     arb_state_a, 2'b01);
        check("t4_resume_pop", src_read_a,  4'b0010);
        repeat (6) cycle();
        check("t4_end_idle",   arb_state_a, 2'b00);
        check("t4_pop_total",  pop_log_a.size(), 5);
        check("t4_push_total", push_log_a.size(), 5);
        check("t4_last_push",  (push_log_a.size() == 5) ? push_log_a[4] : 10'hx, 10'h10e);

        // 5: dst_error[1] pulse sets the sticky flag
        check("t5_err_before", arb_error_a, 1'b0);
        dst_error = 2'b10;
        cycle();
        dst_error = 2'b00;
        check("t5_err_set",    arb_error_a, 1'b1);
        repeat (3) cycle();
        check("t5_err_sticky", arb_error_a, 1'b1);

        // 6: reset with a word in stage 1 and another being popped
        clear_logs();
        load(0, 0, 8'h31);
        load(0, 0, 8'h32);
        load(0, 0, 8'h33);
        load(0, 0, 8'h34);
        cycle();
        check("t6_pop1",       src_read_a,  4'b0001);
        cycle();
        check("t6_pop2",       src_read_a,  4'b0001);
        reset = 1'b1;
        cycle();
        check("t6_no_push",    dst_write_a, 2'b00);
        check("t6_state",      arb_state_a, 2'b00);
        check("t6_err_clr",    arb_error_a, 1'b0);
        check("t6_idle",       idle_a,      1'b1);
        check("t6_no_pop",     src_read_a,  4'b0000);
        reset = 1'b0;
        cycle();
        check("t6_restart",    arb_state_a, 2'b01);
        check("t6_dropped1",   dst_write_a, 2'b00);
        cycle();
        check("t6_dropped2",   dst_write_a, 2'b00);
        cycle();
        check("t6_next_push",  dst_write_a, 2'b10);
        check("t6_next_data",  dst_data_a,  8'h33);
        repeat (4) cycle();
        check("t6_final_idle", idle_a,      1'b1);
        check("t6_final_err",  arb_error_a, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
